// File: rtl/led_pattern_engine.sv
// Purpose: steps one of four LED patterns (bounce, rotate, bar-fill, blink) at a
//          programmable rate, with pause, and drives the LED pins plus a step strobe.
// Latency: leds/step_pulse are registered; a step shows on the edge the counter expires.
// Ports:   system_clk, rst_n (sync, active-low), mode[1:0], step_delay, pause -> step_pulse, leds
module led_pattern_engine #(
  parameter int LED_COUNT  = 6,
  parameter int DIV_WIDTH  = 24,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                 system_clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] step_delay,
  input  logic                 pause,
  output logic                 step_pulse,
  output logic [LED_COUNT-1:0] leds
);

  localparam int LVL_W = $clog2(LED_COUNT + 1);

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BAR    = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LED_COUNT);

  logic [LED_COUNT-1:0] pattern_q, pattern_d;
  logic                 dir_q, dir_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 step_pulse_q, step_pulse_d;
  logic [LVL_W-1:0]     level_n;

  function automatic logic [LED_COUNT-1:0] init_pattern(input logic [1:0] m);
    case (m)
      MODE_BOUNCE, MODE_ROTATE: return LED_COUNT'(1);
      MODE_BAR:                 return '0;
      default:                  return '1;
    endcase
  endfunction

  // Thermometer mask with the low 'lvl' bits set; avoids a 1<<32 overflow at LED_COUNT=32.
  function automatic logic [LED_COUNT-1:0] bar_mask(input logic [LVL_W-1:0] lvl);
    logic [LED_COUNT-1:0] m;
    m = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      m[i] = (i < int'(lvl));
    end
    return m;
  endfunction

  always_comb begin
    pattern_d    = pattern_q;
    dir_d        = dir_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    step_pulse_d = 1'b0;
    level_n      = level_q;

    if (mode != mode_q) begin
      // Mode change restarts the new pattern and wins over pause and any due step.
      mode_d    = mode;
      pattern_d = init_pattern(mode);
      dir_d     = 1'b1;
      level_d   = '0;
      cnt_d     = '0;
    end else if (!pause) begin
      // >= so that lowering step_delay below the current count steps immediately.
      if (cnt_q >= step_delay) begin
        cnt_d        = '0;
        step_pulse_d = 1'b1;
        case (mode_q)
          MODE_BOUNCE: begin
            // Reversal happens in the same step as the move: no dwell at the ends.
            if (LED_COUNT > 1) begin
              if (dir_q && pattern_q[LED_COUNT-1]) begin
                dir_d     = 1'b0;
                pattern_d = pattern_q >> 1;
              end else if (!dir_q && pattern_q[0]) begin
                dir_d     = 1'b1;
                pattern_d = pattern_q << 1;
              end else if (dir_q) begin
                pattern_d = pattern_q << 1;
              end else begin
                pattern_d = pattern_q >> 1;
              end
            end
          end
          MODE_ROTATE: begin
            pattern_d = (pattern_q << 1) | (pattern_q >> (LED_COUNT - 1));
          end
          MODE_BAR: begin
            if (dir_q) begin
              level_n = level_q + LVL_W'(1);
              if (level_n == LVL_MAX) dir_d = 1'b0;
            end else begin
              level_n = level_q - LVL_W'(1);
              if (level_n == '0) dir_d = 1'b1;
            end
            level_d   = level_n;
            pattern_d = bar_mask(level_n);
          end
          default: begin
            pattern_d = ~pattern_q;
          end
        endcase
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      pattern_q    <= init_pattern(mode);
      dir_q        <= 1'b1;
      level_q      <= '0;
      cnt_q        <= '0;
      mode_q       <= mode;
      step_pulse_q <= 1'b0;
    end else begin
      pattern_q    <= pattern_d;
      dir_q        <= dir_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign leds       = pattern_q ^ {LED_COUNT{ACTIVE_LOW}};
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Purpose: randomized and directed stimulus for led_pattern_engine, checked
//          against a step-index reference model that derives each pattern arithmetically.
module tb_led_pattern_engine;

  localparam int N  = 6;
  localparam int DW = 24;

  logic          system_clk = 1'b0;
  logic          rst_n      = 1'b0;
  logic [1:0]    mode       = 2'd0;
  logic [DW-1:0] step_delay = '0;
  logic          pause      = 1'b0;
  logic          step_pulse;
  logic [N-1:0]  leds;

  int errors = 0;
  int checks = 0;
  int pulses_seen = 0;

  // Reference model state: step index within the current mode, divider count, strobe.
  int m_mode  = 0;
  int m_k     = 0;
  int m_cnt   = 0;
  bit m_pulse = 1'b0;

  led_pattern_engine #(.LED_COUNT(N), .DIV_WIDTH(DW), .ACTIVE_LOW(1'b1)) dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .step_delay (step_delay),
    .pause      (pause),
    .step_pulse (step_pulse),
    .leds       (leds)
  );

  always #5 system_clk = ~system_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pattern after k steps from the mode's starting pattern.
  function automatic logic [N-1:0] exp_pattern(input int md, input int k);
    int ph, pos, lvl;
    case (md)
      0: begin
        ph  = k % (2 * N - 2);
        pos = (ph < N) ? ph : (2 * N - 2) - ph;
        return N'(1 << pos);
      end
      1: return N'(1 << (k % N));
      2: begin
        ph  = k % (2 * N);
        lvl = (ph <= N) ? ph : (2 * N) - ph;
        return N'((1 << lvl) - 1);
      end
      default: return (k % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
    endcase
  endfunction

  task automatic model_edge();
    if (!rst_n || int'(mode) != m_mode) begin
      m_mode  = int'(mode);
      m_k     = 0;
      m_cnt   = 0;
      m_pulse = 1'b0;
    end else if (pause) begin
      m_pulse = 1'b0;
    end else if (m_cnt >= int'(step_delay)) begin
      m_cnt   = 0;
      m_k++;
      m_pulse = 1'b1;
    end else begin
      m_cnt++;
      m_pulse = 1'b0;
    end
  endtask

  // One clock: update the model with the inputs present at the edge, then compare.
  task automatic cycle();
    @(posedge system_clk);
    model_edge();
    #1;
    check("leds", 32'(leds), 32'(exp_pattern(m_mode, m_k) ^ {N{1'b1}}));
    check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    if (step_pulse) pulses_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [N-1:0] frozen;

  initial begin
    // 1. Reset + bounce, step every 4 cycles.
    rst_n = 1'b0; mode = 2'd0; step_delay = DW'(3); pause = 1'b0;
    cycle();
    check("reset_leds", 32'(leds), 32'(6'b111110));
    check("reset_pulse", 32'(step_pulse), 32'(0));
    rst_n = 1'b1;
    pulses_seen = 0;
    run(40);
    check("bounce_pulses_per_40", 32'(pulses_seen), 32'(10));
    check("bounce_period_back", 32'(leds), 32'(6'b111110));

    // 2. Rotate with step every cycle.
    mode = 2'd1; step_delay = '0;
    cycle();
    pulses_seen = 0;
    run(12);
    check("rotate_pulses_per_12", 32'(pulses_seen), 32'(12));

    // 3. Bar-fill, step every 2 cycles, 24-cycle period.
    mode = 2'd2; step_delay = DW'(1);
    cycle();
    pulses_seen = 0;
    run(24);
    check("bar_pulses_per_24", 32'(pulses_seen), 32'(12));
    check("bar_period_back", 32'(leds), 32'(6'b111111));

    // 4. Pause mid-bounce, then mode change to blink.
    mode = 2'd0; step_delay = DW'(3);
    run(7);
    pause = 1'b1;
    frozen = leds;
    pulses_seen = 0;
    run(20);
    check("pause_pulses", 32'(pulses_seen), 32'(0));
    check("pause_frozen", 32'(leds), 32'(frozen));
    pause = 1'b0; mode = 2'd3;
    cycle();
    check("blink_start_all_on", 32'(leds), 32'(6'b000000));
    run(12);

    // 5. Lower step_delay from 100 to 2 while the count sits at 50.
    mode = 2'd1; step_delay = DW'(100);
    cycle();
    run(50);
    step_delay = DW'(2);
    cycle();
    check("delay_drop_immediate_step", 32'(step_pulse), 32'(1));
    pulses_seen = 0;
    run(9);
    check("delay_drop_pulses_per_9", 32'(pulses_seen), 32'(3));

    // 6. Reset mid-run in bar mode at level 4.
    mode = 2'd2; step_delay = '0;
    cycle();
    run(4);
    check("bar_level4", 32'(leds), 32'(6'b110000));
    rst_n = 1'b0;
    cycle();
    check("bar_reset_all_off", 32'(leds), 32'(6'b111111));
    rst_n = 1'b1;
    run(14);

    // Random phase: occasional mode changes, pauses, resets, delay changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) step_delay = DW'($urandom_range(0, 5));
      pause = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
Parametrised LED pattern generator for the board LED bank. It drives LED_COUNT LEDs with one of four run-time selectable patterns: bounce, rotate, bar-fill and blink. The step rate is programmable at run time, and the block supports pause. It sits directly between the system clock domain and the LED pins, and it also provides a step strobe that other logic (e.g. UART status) can use.

Parameters:
LED_COUNT, 6, number of LEDs driven; legal range 1..32.
DIV_WIDTH, 24, width of the step-delay counter and of the step_delay port.
ACTIVE_LOW, 1, 1 means LED pins are active-low, so the output is the inverted pattern; 0 means outputs are not inverted.

Ports:
system_clk  in  1  system clock, nominally 27 MHz.
rst_n  in  1  reset; one clock; reset is synchronous and active-low.
mode  in  2  0=bounce, 1=rotate, 2=bar-fill, 3=blink.
step_delay  in  DIV_WIDTH  step period minus one, in system_clk cycles.
pause  in  1  1 freezes the pattern and the step counter.
step_pulse  out  1  one-cycle strobe on every pattern step.
leds  out  LED_COUNT  LED pin drive, polarity per ACTIVE_LOW.

Behaviour:
- Internal state:
  - pattern[LED_COUNT-1:0]
  - dir (1=up, towards MSB)
  - level (0..LED_COUNT)
  - cnt[DIV_WIDTH-1:0]
  - mode_q
- Output mapping:
  - leds = pattern XOR {LED_COUNT{ACTIVE_LOW}}.
  - leds is registered-state-derived, with no combinational path from the inputs.
- Reset (rst_n=0 at a clock edge):
  - cnt=0, dir=1, level=0, step_pulse=0, mode_q=mode.
  - pattern=init(mode), where init is: bounce/rotate=...0001, bar=all 0, blink=all 1.
  - With ACTIVE_LOW=1 and mode=0, leds=6'b111110 after reset.
- Mode change (mode != mode_q, not in reset):
  - Next edge: mode_q=mode, pattern=init(mode), dir=1, level=0, cnt=0, step_pulse=0.
  - This takes priority over pause and over any step in that cycle.
- Step timing:
  - If pause=1: cnt, pattern and all other state hold, and step_pulse=0.
  - Else if cnt >= step_delay: cnt=0, step_pulse=1, and a pattern step is taken.
  - Else: cnt=cnt+1 and step_pulse=0.
  - Resulting step period is step_delay+1 cycles; step_delay=0 steps every cycle.
  - The comparison uses >= so that lowering step_delay mid-count takes effect immediately.
- Pattern step, bounce mode:
  - Moves one position per step; the reversal happens in the same step as the move, so there is no dwell at the ends.
  - If dir=1 and pattern[MSB]=1: dir=0, shift right.
  - Else if dir=0 and pattern[0]=1: dir=1, shift left.
  - Otherwise shift in dir.
  - Sequence period is 2*LED_COUNT-2 steps.
  - LED_COUNT=1: pattern stays 1.
- Pattern step, rotate mode:
  - Rotate left by 1; MSB wraps to bit 0.
  - Period is LED_COUNT steps.
- Pattern step, bar mode:
  - pattern = (1<<level)-1.
  - level runs 0 up to LED_COUNT, then back down to 0.
  - Direction is reversed in the same step the end value is reached.
  - Period is 2*LED_COUNT steps.
- Pattern step, blink mode:
  - pattern = ~pattern, so the bank toggles between all on and all off.
- pause=1 asserted together with a step-due cycle: no step, and step_pulse=0.
- Reset mid-step overrides everything.

Test Plan:
1. Reset + bounce: ACTIVE_LOW=1, LED_COUNT=6, step_delay=3, mode=0 -> leds=111110 after reset. Pattern changes every 4 cycles: 000010, 000100, ..., 100000, 010000, ..., 000001. Period is 40 cycles, and step_pulse appears exactly 10 times per period.
2. Rotate: mode=1, step_delay=0 -> pattern advances every cycle: 000001, 000010, ..., 100000, 000001. step_pulse is held high continuously.
3. Bar mode: mode=2, step_delay=1 -> pattern sequence 000000, 000001, 000011, ..., 111111, 011111, ..., 000000. Steps occur every 2 cycles, and the full period is 24 cycles.
4. Pause and mode change: pause=1 for 20 cycles mid-bounce -> leds and cnt are frozen and step_pulse stays 0. Then switch mode from 0 to 3 -> the next edge gives pattern=111111 and cnt=0. Blink toggles every step_delay+1 cycles.
5. Delay change: step_delay lowered from 100 to 2 while cnt=50 -> a step occurs on the next edge, and subsequent steps occur every 3 cycles.
6. Reset mid-run: rst_n=0 for one edge during bar mode at level=4 -> pattern returns to all 0, level=0 and cnt=0. The sequence then restarts from level 0.
